// File: rtl/controller_iram_loader.sv
// Boot loader: framed byte stream -> little-endian words -> instruction RAM, CPU held in reset until done.
// Optional checksum byte and verification enabled with `define IRAM_LOADER_CSUM_EN.
module controller_iram_loader #(
  parameter int          ADDR_W = 9,
  parameter int          DEPTH  = 512,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic [31:0]       mem_writedata,
  output logic              cpu_reset_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code
);

  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
`ifdef IRAM_LOADER_CSUM_EN
  localparam logic [1:0] ERR_CSUM  = 2'd3;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_MAGIC,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef IRAM_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        word_buf_q, word_buf_d;
`ifdef IRAM_LOADER_CSUM_EN
  logic [7:0]         acc_q, acc_d;
`endif

  logic               in_ready_q, in_ready_d;
  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_reset_req_q, cpu_reset_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         error_code_q, error_code_d;

  logic               take;
  logic [15:0]        len_full;

  // in_ready is registered from the next state, so it already reflects the accepting state.
  assign take     = in_valid & in_ready_q;
  assign len_full = {in_data, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    word_buf_d   = word_buf_q;
`ifdef IRAM_LOADER_CSUM_EN
    acc_d        = acc_q;
`endif
    error_code_d = error_code_q;
    mem_wr_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_MAGIC;
          error_code_d = ERR_NONE;
          word_cnt_d   = '0;
          byte_cnt_d   = '0;
`ifdef IRAM_LOADER_CSUM_EN
          acc_d        = '0;
`endif
        end
      end
      S_MAGIC: begin
        if (take) begin
          if (in_data != MAGIC) begin
            state_d      = S_ERROR;
            error_code_d = ERR_MAGIC;
          end else begin
            state_d = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (take) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (take) begin
          if (len_full == 16'd0 || len_full > DEPTH_LEN) begin
            state_d      = S_ERROR;
            error_code_d = ERR_LEN;
          end else begin
            len_d   = len_full[CNT_W-1:0];
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (take) begin
`ifdef IRAM_LOADER_CSUM_EN
          acc_d = acc_q ^ in_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              // Fourth byte: launch the write strobe for the next cycle.
              mem_wr_d    = 1'b1;
              mem_addr_d  = word_cnt_q[ADDR_W-1:0];
              mem_wdata_d = {in_data, word_buf_q};
              word_cnt_d  = word_cnt_q + CNT_W'(1);
              state_d     = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (word_cnt_q == len_q) begin
`ifdef IRAM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_PAYLOAD;
        end
      end
`ifdef IRAM_LOADER_CSUM_EN
      S_CSUM: begin
        if (take) begin
          if (in_data == acc_q) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_ERROR;
            error_code_d = ERR_CSUM;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Status outputs are a registered decode of the next state.
    in_ready_d = (state_d == S_MAGIC) || (state_d == S_LEN_LO) ||
                 (state_d == S_LEN_HI) || (state_d == S_PAYLOAD)
`ifdef IRAM_LOADER_CSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    busy_d          = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d          = (state_d == S_DONE);
    error_d         = (state_d == S_ERROR);
    cpu_reset_req_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      len_lo_q        <= '0;
      len_q           <= '0;
      word_cnt_q      <= '0;
      byte_cnt_q      <= '0;
      word_buf_q      <= '0;
`ifdef IRAM_LOADER_CSUM_EN
      acc_q           <= '0;
`endif
      in_ready_q      <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cpu_reset_req_q <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      error_code_q    <= ERR_NONE;
    end else begin
      state_q         <= state_d;
      len_lo_q        <= len_lo_d;
      len_q           <= len_d;
      word_cnt_q      <= word_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
      word_buf_q      <= word_buf_d;
`ifdef IRAM_LOADER_CSUM_EN
      acc_q           <= acc_d;
`endif
      in_ready_q      <= in_ready_d;
      mem_wr_q        <= mem_wr_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cpu_reset_req_q <= cpu_reset_req_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      error_code_q    <= error_code_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign mem_address     = mem_addr_q;
  assign mem_byteenable  = {4{mem_wr_q}};
  assign mem_chipselect  = mem_wr_q;
  assign mem_write       = mem_wr_q;
  assign mem_debugaccess = mem_wr_q;
  assign mem_writedata   = mem_wdata_q;
  assign cpu_reset_req   = cpu_reset_req_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign error_code      = error_code_q;

endmodule

// File: tb/tb_controller_iram_loader.sv
// Scoreboard bench for controller_iram_loader: stimulus pushes expected writes/status, a negedge monitor pops and compares.
module tb_controller_iram_loader;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_debugaccess;
  logic [31:0]       mem_writedata;
  logic              cpu_reset_req, busy, done, error;
  logic [1:0]        error_code;

  always #5 clk = ~clk;

  controller_iram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_debugaccess(mem_debugaccess), .mem_writedata(mem_writedata),
    .cpu_reset_req(cpu_reset_req), .busy(busy), .done(done),
    .error(error), .error_code(error_code)
  );

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic done; logic error; logic [1:0] code; logic cpu; } st_t;
  typedef struct packed {
    logic [31:0] at;
    logic in_ready; logic wr; logic [ADDR_W-1:0] addr; logic [31:0] wd;
    logic cpu; logic busy; logic done; logic error; logic [1:0] code;
  } snap_t;

  wr_t   wr_q[$];
  st_t   st_q[$];
  snap_t sn_q[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int to_cnt = 0, to_seen = 0;
  logic prev_busy = 1'b0;

  // Monitor: sole owner of the counters.
  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (to_cnt != to_seen) begin
      n_vec++; n_err++;
      $display("FAIL timeout: %0d bounded waits expired, required 0", to_cnt - to_seen);
      to_seen = to_cnt;
    end
    if (mem_write || mem_chipselect || mem_debugaccess || mem_byteenable != 4'h0) begin
      n_vec++;
      if (wr_q.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: addr=%0d data=%h, required no write", mem_address, mem_writedata);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        if (!(mem_write && mem_chipselect && mem_debugaccess && mem_byteenable == 4'hF &&
              mem_address == e.addr && mem_writedata == e.data)) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=%h be=%h cs/wr/dbg=%b%b%b, required addr=%0d data=%h be=f 111",
                   mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write,
                   mem_debugaccess, e.addr, e.data);
        end
      end
    end
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      n_vec++;
      if (st_q.size() == 0) begin
        n_err++;
        $display("FAIL status_unexpected: busy fell, done=%b error=%b code=%0d", done, error, error_code);
      end else begin
        st_t s;
        s = st_q.pop_front();
        if (done !== s.done || error !== s.error || error_code !== s.code ||
            cpu_reset_req !== s.cpu || wr_q.size() != 0) begin
          n_err++;
          $display("FAIL status: got done=%b err=%b code=%0d cpu_rst=%b pend_wr=%0d, required %b %b %0d %b 0",
                   done, error, error_code, cpu_reset_req, wr_q.size(), s.done, s.error, s.code, s.cpu);
        end
      end
    end
    prev_busy = busy;
    if (sn_q.size() != 0 && sn_q[0].at == cyc) begin
      snap_t n;
      n = sn_q.pop_front();
      n_vec++;
      if (in_ready !== n.in_ready || mem_write !== n.wr || mem_chipselect !== n.wr ||
          mem_debugaccess !== n.wr || mem_byteenable !== {4{n.wr}} || mem_address !== n.addr ||
          mem_writedata !== n.wd || cpu_reset_req !== n.cpu || busy !== n.busy ||
          done !== n.done || error !== n.error || error_code !== n.code ||
          wr_q.size() != 0 || st_q.size() != 0) begin
        n_err++;
        $display("FAIL snapshot: got rdy=%b wr=%b a=%0d d=%h cpu=%b busy=%b done=%b err=%b code=%0d q=%0d/%0d, required %b %b %0d %h %b %b %b %b %0d 0/0",
                 in_ready, mem_write, mem_address, mem_writedata, cpu_reset_req, busy, done, error,
                 error_code, wr_q.size(), st_q.size(), n.in_ready, n.wr, n.addr, n.wd, n.cpu,
                 n.busy, n.done, n.error, n.code);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    bit ok;
    if (bp) repeat ($urandom_range(0, 2)) tick();
    in_data = b; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) to_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = !busy;
    end
    if (!ok) to_cnt++;
    tick(); tick();
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d);
    wr_q.push_back('{addr: ADDR_W'(a), data: d});
  endtask

  task automatic exp_st(input logic dn, input logic er, input logic [1:0] c, input logic cpu);
    st_q.push_back('{done: dn, error: er, code: c, cpu: cpu});
  endtask

  // Expectation for the outputs at the next monitor sample.
  task automatic exp_snap(input logic cpu, input logic dn);
    snap_t n;
    n = '0;
    n.at = 32'(cyc + 1);
    n.cpu = cpu;
    n.done = dn;
    sn_q.push_back(n);
  endtask

  task automatic send_frame(input logic [7:0] b[]);
    foreach (b[i]) send_byte(b[i], 1'b0);
  endtask

  initial begin
    logic [7:0] f_ok[], f_bad[], f_rst[], f_two[];
    logic [7:0] csum, bb;
    logic [31:0] w;

    f_ok  = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    f_rst = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    f_two = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    // Reset state
    repeat (3) tick();
    exp_snap(1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // Checksum path
    exp_wr(0, 32'h44332211); exp_wr(1, 32'h88776655);
    exp_st(1'b1, 1'b0, 2'd0, 1'b0);
    pulse_start();
    send_frame(f_ok);
`ifdef IRAM_LOADER_CSUM_EN
    send_byte(8'h88, 1'b0);
`endif
    wait_idle();

    // Bad magic
    exp_st(1'b0, 1'b1, 2'd1, 1'b1);
    pulse_start();
    send_byte(8'h5A, 1'b0);
    wait_idle();

    // Bad length 513, then 0
    exp_st(1'b0, 1'b1, 2'd2, 1'b1);
    pulse_start();
    f_bad = '{8'hA5, 8'h01, 8'h02};
    send_frame(f_bad);
    wait_idle();
    exp_st(1'b0, 1'b1, 2'd2, 1'b1);
    pulse_start();
    f_bad = '{8'hA5, 8'h00, 8'h00};
    send_frame(f_bad);
    wait_idle();

    // Checksum mismatch (without the checksum stage the frame simply completes)
    exp_wr(0, 32'h44332211); exp_wr(1, 32'h88776655);
`ifdef IRAM_LOADER_CSUM_EN
    exp_st(1'b0, 1'b1, 2'd3, 1'b1);
`else
    exp_st(1'b1, 1'b0, 2'd0, 1'b0);
`endif
    pulse_start();
    send_frame(f_ok);
`ifdef IRAM_LOADER_CSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    wait_idle();

    // Full 512-word image with back-pressure and an ignored mid-load start
    csum = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        bb = 8'(i * 4 + k) ^ 8'h3C;
        w[k*8 +: 8] = bb;
      end
      exp_wr(i, w);
    end
    exp_st(1'b1, 1'b0, 2'd0, 1'b0);
    pulse_start();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i == 200 && k == 2) pulse_start();
        bb = 8'(i * 4 + k) ^ 8'h3C;
        csum = csum ^ bb;
        send_byte(bb, 1'b1);
      end
    end
`ifdef IRAM_LOADER_CSUM_EN
    send_byte(csum, 1'b1);
`endif
    wait_idle();

    // Reset mid-load after 5 payload bytes
    exp_wr(0, 32'h44332211);
    exp_st(1'b0, 1'b0, 2'd0, 1'b1);
    pulse_start();
    send_frame(f_rst);
    reset_n = 1'b0;
    tick();
    exp_snap(1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // Fresh 2-word load from address 0
    exp_wr(0, 32'h04030201); exp_wr(1, 32'h08070605);
    exp_st(1'b1, 1'b0, 2'd0, 1'b0);
    pulse_start();
    send_frame(f_two);
`ifdef IRAM_LOADER_CSUM_EN
    send_byte(8'h08, 1'b0);
`endif
    wait_idle();
    exp_snap(1'b0, 1'b1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
